// File: rtl/stage1_fetch_pkg.sv
// stage1_fetch_pkg: shared CPU header with bus widths, reset PC and the branch bus layout.
package stage1_fetch_pkg;
    localparam int WIDTH_FS_TO_DS_BUS = 64;
    localparam int WIDTH_BR_BUS = 34;
    localparam logic [31:0] RESET_PC = 32'h1C00_0000;
    typedef struct packed {
        logic        cancel;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;
endpackage

// File: rtl/stage1_fetch_if.sv
// stage1_fetch_if: decode handshake, branch bus and instruction SRAM port of the fetch stage.
interface stage1_fetch_if;
    import stage1_fetch_pkg::*;
    logic                          ds_allow_in;
    logic [WIDTH_BR_BUS-1:0]       br_bus;
    logic                          fs_to_ds_valid;
    logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus;
    logic                          inst_sram_en;
    logic [3:0]                    inst_sram_we;
    logic [31:0]                   inst_sram_addr;
    logic [31:0]                   inst_sram_wdata;
    logic [31:0]                   inst_sram_rdata;
    modport master(
        input  ds_allow_in, br_bus, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
    modport slave(
        output ds_allow_in, br_bus, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/stage1_fetch.sv
// stage1_fetch: instruction fetch stage with one-cycle SRAM latency, stall buffer and deferred branch redirect.
module stage1_fetch
    import stage1_fetch_pkg::*;
(
    input logic            clk,
    input logic            reset,
    stage1_fetch_if.master fs
);
    br_bus_t     br;
    logic        fs_valid, fs_allow_in, br_pend, inst_buf_valid, unused_br_taken;
    logic [31:0] fs_pc, seq_pc, nextpc, br_pend_target, inst_buf, fs_inst;
    assign br = br_bus_t'(fs.br_bus);
    assign unused_br_taken = br.taken;
    assign fs_allow_in = !fs_valid || fs.ds_allow_in;
    assign seq_pc = fs_pc + 32'd4;
    assign nextpc = br.cancel ? br.target : br_pend ? br_pend_target : seq_pc;
    // SRAM data is only valid one cycle after a request, so a stalled instruction is held locally
    assign fs_inst = inst_buf_valid ? inst_buf : fs.inst_sram_rdata;
    assign fs.inst_sram_en = !reset && fs_allow_in;
    assign fs.inst_sram_we = 4'h0;
    assign fs.inst_sram_addr = nextpc;
    assign fs.inst_sram_wdata = 32'h0;
    assign fs.fs_to_ds_valid = fs_valid;
    assign fs.fs_to_ds_bus = {fs_inst, fs_pc};
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid       <= 1'b0;
            fs_pc          <= RESET_PC - 32'd4;
            br_pend        <= 1'b0;
            br_pend_target <= 32'h0;
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'h0;
        end else begin
            if (fs.inst_sram_en) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end else if (br.cancel || (fs_valid && fs.ds_allow_in)) begin
                fs_valid <= 1'b0;
            end
            // any issued request consumes the pending target or is itself the newer redirect
            if (fs.inst_sram_en) begin
                br_pend <= 1'b0;
            end else if (br.cancel) begin
                br_pend        <= 1'b1;
                br_pend_target <= br.target;
            end
            if (br.cancel || (fs_valid && fs.ds_allow_in)) begin
                inst_buf_valid <= 1'b0;
            end else if (fs_valid && !inst_buf_valid) begin
                inst_buf_valid <= 1'b1;
                inst_buf       <= fs.inst_sram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_stage1_fetch.sv
// tb_stage1_fetch: scenario tasks for the fetch stage with a handoff scoreboard against a synchronous SRAM model.
module tb_stage1_fetch;
    import stage1_fetch_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic corrupt = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    always #5 clk = ~clk;
    stage1_fetch_if sif();
    stage1_fetch dut(.clk(clk), .reset(reset), .fs(sif.master));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // synchronous-read instruction memory; optionally garbles its output while not read
    always @(posedge clk) begin
        if (sif.inst_sram_en) sif.inst_sram_rdata <= mem_word(sif.inst_sram_addr);
        else if (corrupt) sif.inst_sram_rdata <= 32'hDEAD_BEEF;
    end

    // scoreboard: every accepted handoff must match the oldest fetch still expected; cancel drops the offered one
    always @(negedge clk) begin
        if (!reset && sif.fs_to_ds_valid) begin
            if (sif.br_bus[33]) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (sif.ds_allow_in) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL handoff: offered %h, none expected", sif.fs_to_ds_bus);
                end else if (sif.fs_to_ds_bus !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL handoff: got %h want %h", sif.fs_to_ds_bus, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic go(input logic allow, input logic cancel, input logic [31:0] tgt);
        sif.ds_allow_in = allow;
        sif.br_bus = {cancel, cancel, tgt};
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        go(1'b1, 1'b0, 32'h0);
        tick;
        tick;
        n_cmp++;
        if (sif.inst_sram_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", sif.inst_sram_en); end
        n_cmp++;
        if (sif.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sif.fs_to_ds_valid); end
        n_cmp++;
        if ({sif.inst_sram_we, sif.inst_sram_wdata} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_we_wdata: got %h/%h want 0/0", sif.inst_sram_we, sif.inst_sram_wdata);
        end
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a;
            a = RESET_PC + 32'(4 * i);
            go(1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== a) begin
                n_err++;
                $display("FAIL seq_addr: got en=%b %h want en=1 %h", sif.inst_sram_en, sif.inst_sram_addr, a);
            end
            exp_q.push_back({mem_word(a), a});
            tick;
            n_cmp++;
            if (sif.fs_to_ds_valid !== 1'b1 || sif.fs_to_ds_bus[31:0] !== a) begin
                n_err++;
                $display("FAIL seq_pc: got v=%b %h want v=1 %h", sif.fs_to_ds_valid, sif.fs_to_ds_bus[31:0], a);
            end
        end
    endtask

    task automatic test_stall;
        logic [63:0] held;
        held = {mem_word(32'h1C00_0010), 32'h1C00_0010};
        corrupt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (sif.inst_sram_en !== 1'b0) begin n_err++; $display("FAIL stall_en: got %b want 0", sif.inst_sram_en); end
            n_cmp++;
            if (sif.fs_to_ds_bus !== held) begin n_err++; $display("FAIL stall_hold: got %h want %h", sif.fs_to_ds_bus, held); end
            tick;
        end
        corrupt = 1'b0;
        go(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== 32'h1C00_0014) begin
            n_err++;
            $display("FAIL stall_release: got en=%b %h want en=1 1c000014", sif.inst_sram_en, sif.inst_sram_addr);
        end
        exp_q.push_back({mem_word(32'h1C00_0014), 32'h1C00_0014});
        tick;
    endtask

    task automatic test_cancel;
        go(1'b1, 1'b1, 32'h1C00_0100);
        n_cmp++;
        if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== 32'h1C00_0100) begin
            n_err++;
            $display("FAIL cancel_addr: got en=%b %h want en=1 1c000100", sif.inst_sram_en, sif.inst_sram_addr);
        end
        exp_q.push_back({mem_word(32'h1C00_0100), 32'h1C00_0100});
        tick;
        go(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (sif.fs_to_ds_valid !== 1'b1 || sif.fs_to_ds_bus[31:0] !== 32'h1C00_0100) begin
            n_err++;
            $display("FAIL cancel_pc: got v=%b %h want v=1 1c000100", sif.fs_to_ds_valid, sif.fs_to_ds_bus[31:0]);
        end
        n_cmp++;
        if (sif.inst_sram_addr !== 32'h1C00_0104) begin n_err++; $display("FAIL cancel_next: got %h want 1c000104", sif.inst_sram_addr); end
        exp_q.push_back({mem_word(32'h1C00_0104), 32'h1C00_0104});
        tick;
    endtask

    task automatic test_cancel_stall;
        go(1'b0, 1'b0, 32'h0);
        tick;
        go(1'b0, 1'b1, 32'h1C00_0200);
        n_cmp++;
        if (sif.inst_sram_en !== 1'b0) begin n_err++; $display("FAIL cs_no_req: got %b want 0", sif.inst_sram_en); end
        tick;
        go(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (sif.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL cs_valid: got %b want 0", sif.fs_to_ds_valid); end
        n_cmp++;
        if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== 32'h1C00_0200) begin
            n_err++;
            $display("FAIL cs_addr: got en=%b %h want en=1 1c000200", sif.inst_sram_en, sif.inst_sram_addr);
        end
        exp_q.push_back({mem_word(32'h1C00_0200), 32'h1C00_0200});
        tick;
        go(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (sif.fs_to_ds_valid !== 1'b1 || sif.fs_to_ds_bus !== {mem_word(32'h1C00_0200), 32'h1C00_0200}) begin
            n_err++;
            $display("FAIL cs_bus: got v=%b %h want v=1 %h", sif.fs_to_ds_valid, sif.fs_to_ds_bus, {mem_word(32'h1C00_0200), 32'h1C00_0200});
        end
        n_cmp++;
        if (sif.inst_sram_addr !== 32'h1C00_0204) begin n_err++; $display("FAIL cs_next: got %h want 1c000204", sif.inst_sram_addr); end
        exp_q.push_back({mem_word(32'h1C00_0204), 32'h1C00_0204});
        tick;
    endtask

    task automatic test_wrap;
        logic [31:0] seq[3];
        seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            go(1'b1, i == 0, 32'hFFFF_FFF8);
            n_cmp++;
            if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== seq[i]) begin
                n_err++;
                $display("FAIL wrap_addr: got en=%b %h want en=1 %h", sif.inst_sram_en, sif.inst_sram_addr, seq[i]);
            end
            exp_q.push_back({mem_word(seq[i]), seq[i]});
            tick;
        end
        go(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (sif.fs_to_ds_valid !== 1'b1 || sif.fs_to_ds_bus[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_pc: got v=%b %h want v=1 00000000", sif.fs_to_ds_valid, sif.fs_to_ds_bus[31:0]);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        go(1'b0, 1'b0, 32'h0);
        tick;
        exp_q.delete();
        n_cmp++;
        if (sif.fs_to_ds_valid !== 1'b0 || sif.inst_sram_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b en=%b want 0/0", sif.fs_to_ds_valid, sif.inst_sram_en);
        end
        reset = 1'b0;
        go(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL rst_addr: got en=%b %h want en=1 %h", sif.inst_sram_en, sif.inst_sram_addr, RESET_PC);
        end
        exp_q.push_back({mem_word(RESET_PC), RESET_PC});
        tick;
        go(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (sif.fs_to_ds_bus !== {mem_word(RESET_PC), RESET_PC}) begin
            n_err++;
            $display("FAIL rst_inst: got %h want %h", sif.fs_to_ds_bus, {mem_word(RESET_PC), RESET_PC});
        end
        tick;
        go(1'b0, 1'b1, 32'h1C00_0300);
        tick;
        reset = 1'b1;
        go(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (sif.inst_sram_en !== 1'b0) begin n_err++; $display("FAIL rst2_en: got %b want 0", sif.inst_sram_en); end
        tick;
        exp_q.delete();
        reset = 1'b0;
        go(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (sif.inst_sram_en !== 1'b1 || sif.inst_sram_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL rst2_addr: got en=%b %h want en=1 %h", sif.inst_sram_en, sif.inst_sram_addr, RESET_PC);
        end
        exp_q.push_back({mem_word(RESET_PC), RESET_PC});
        tick;
        go(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (sif.inst_sram_addr !== RESET_PC + 32'd4) begin
            n_err++;
            $display("FAIL rst2_next: got %h want %h", sif.inst_sram_addr, RESET_PC + 32'd4);
        end
        exp_q.push_back({mem_word(RESET_PC + 32'd4), RESET_PC + 32'd4});
        tick;
    endtask

    initial begin
        sif.inst_sram_rdata = 32'h0;
        test_reset;
        test_sequential;
        test_stall;
        test_cancel;
        test_cancel_stall;
        test_wrap;
        test_reset_mid;
        reset = 1'b1;
        go(1'b0, 1'b0, 32'h0);
        tick;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
